// File: rtl/ogege_pkg.sv
// Shared types and constants for the ogege display command path.
// The opcode field constants are shared by the issuer and the
// text_area8x8 and canvas renderers, so all sides decode the same way.
package ogege_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } cmd_state_t;

    localparam int CMD_W_DEFAULT = 32;

    // Opcode occupies the top byte of every command word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;

    localparam logic [7:0] OPC_NOP          = 8'h00;
    localparam logic [7:0] OPC_TEXT_PUTC    = 8'h01;
    localparam logic [7:0] OPC_TEXT_CURSOR  = 8'h02;
    localparam logic [7:0] OPC_TEXT_CLEAR   = 8'h03;
    localparam logic [7:0] OPC_CANVAS_PIXEL = 8'h10;
    localparam logic [7:0] OPC_CANVAS_FILL  = 8'h11;
    localparam logic [7:0] OPC_SET_COLOR    = 8'h20;

    // Extract the opcode byte from a command word.
    function automatic logic [7:0] cmd_opcode(input logic [CMD_W_DEFAULT-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cmd_issuer_fifo.sv
// Registered-flag synchronous FIFO with a first-word-fall-through head.
// Pointers carry one extra MSB so full and empty can be told apart when
// the index bits match. A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             full_q;
    logic             empty_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = i_push && !full_q;
    assign pop_ok  = i_pop && !empty_q;

    // Next pointer values and the occupancy they imply (modulo difference).
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        level_d  = wr_ptr_d - rd_ptr_d;
    end

    // Pointers and flags are registered so consumers see glitch-free status.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    // Storage array; not reset since validity is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_level = level_q;

endmodule

// File: rtl/cmd_issuer.sv
// Command bus producer: queues host command words and replays them onto
// cmd_clk/cmd_data with programmable setup, strobe and hold timing,
// optionally launching new commands only during display blanking.
module cmd_issuer
    import ogege_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int CMD_W      = CMD_W_DEFAULT,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int BLANK_ONLY = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_stb,
    input  logic [CMD_W-1:0]         i_wr_data,
    input  logic                     i_blank,
    input  logic                     i_ovf_clr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_busy,
    output logic                     o_cmd_clk,
    output logic [CMD_W-1:0]         o_cmd_data,
    output logic [15:0]              o_sent_count
);

    // Counter only needs to hold the largest phase length minus one.
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    cmd_state_t          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                cmd_clk_q;
    logic [CMD_W-1:0]    cmd_data_q;
    logic                busy_q;
    logic [15:0]         sent_q;
    logic                ovf_q;
    logic                ovf_d;

    logic [CMD_W-1:0]    fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                blank_ok;
    logic                launch;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_wr_stb),
        .i_data  (i_wr_data),
        .i_pop   (launch),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

    assign blank_ok = (BLANK_ONLY == 0) || i_blank;
    assign launch   = (state_q == IDLE) && !fifo_empty && blank_ok;

    // Sticky overflow: a dropped push sets it, and a set beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (i_wr_stb && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Transfer sequencer: data is latched on launch, then setup, strobe, hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_clk_q  <= 1'b0;
            cmd_data_q <= '0;
            busy_q     <= 1'b0;
            sent_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        cmd_data_q <= fifo_head;
                        cnt_q      <= SETUP_LD;
                        busy_q     <= 1'b1;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        cmd_clk_q <= 1'b1;
                        cnt_q     <= PULSE_LD;
                        state_q   <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        cmd_clk_q <= 1'b0;
                        cnt_q     <= HOLD_LD;
                        sent_q    <= sent_q + 16'd1;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    cmd_clk_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_full       = fifo_full;
    assign o_empty      = fifo_empty;
    assign o_overflow   = ovf_q;
    assign o_busy       = busy_q;
    assign o_cmd_clk    = cmd_clk_q;
    assign o_cmd_data   = cmd_data_q;
    assign o_sent_count = sent_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Self-checking bench for cmd_issuer: default-timing instance driven by
// vector tables and directed sequences, plus a slow-timing instance
// driven with random traffic and checked by a waveform window analysis.
module tb_cmd_issuer;

    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance signals
    logic           rst, wrStb, blank, ovfClr;
    logic [CW-1:0]  wrData;
    logic           full, empty, overflow, busy, cmdClk;
    logic [4:0]     level;
    logic [CW-1:0]  cmdData;
    logic [15:0]    sentCount;

    // Timing-sweep instance signals (setup 3, pulse 1, hold 2)
    logic           rstT, wrStbT, blankT, ovfClrT;
    logic [CW-1:0]  wrDataT;
    logic           fullT, emptyT, overflowT, busyT, cmdClkT;
    logic [4:0]     levelT;
    logic [CW-1:0]  cmdDataT;
    logic [15:0]    sentCountT;

    localparam int TS = 3;
    localparam int TP = 1;
    localparam int TH = 2;

    cmd_issuer #(
        .DEPTH(16), .CMD_W(CW), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1), .BLANK_ONLY(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_stb(wrStb), .i_wr_data(wrData),
        .i_blank(blank), .i_ovf_clr(ovfClr), .o_full(full), .o_empty(empty),
        .o_level(level), .o_overflow(overflow), .o_busy(busy), .o_cmd_clk(cmdClk),
        .o_cmd_data(cmdData), .o_sent_count(sentCount)
    );

    cmd_issuer #(
        .DEPTH(16), .CMD_W(CW), .SETUP_CYC(TS), .PULSE_CYC(TP), .HOLD_CYC(TH), .BLANK_ONLY(1)
    ) dutT (
        .i_clk(clk), .i_rst(rstT), .i_wr_stb(wrStbT), .i_wr_data(wrDataT),
        .i_blank(blankT), .i_ovf_clr(ovfClrT), .o_full(fullT), .o_empty(emptyT),
        .o_level(levelT), .o_overflow(overflowT), .o_busy(busyT), .o_cmd_clk(cmdClkT),
        .o_cmd_data(cmdDataT), .o_sent_count(sentCountT)
    );

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic          wrStb;
        logic [CW-1:0] wrData;
        logic          blank;
        logic          ovfClr;
        logic [4:0]    expLevel;
        logic          expFull;
        logic          expEmpty;
        logic          expOvf;
        logic          expBusy;
        logic          expClk;
        logic [CW-1:0] expData;
    } vec_t;

    vec_t vecs[23];

    // Strobe monitor for the default instance: records data and cycle at each rise.
    int            cyc = 0;
    logic          prevClk = 1'b0;
    logic [CW-1:0] riseData[$];
    int            riseCyc[$];

    // Cycle counter used to measure strobe spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture rising strobes mid-cycle, well away from the active edge.
    always @(negedge clk) begin
        if (cmdClk && !prevClk) begin
            riseData.push_back(cmdData);
            riseCyc.push_back(cyc);
        end
        prevClk = cmdClk;
    end

    // Waveform history of the sweep instance for the window analysis.
    logic          recT = 1'b0;
    int            nT = 0;
    logic          clkHist[4096];
    logic [CW-1:0] dataHist[4096];

    // Record one sample per cycle of the sweep instance's bus while enabled.
    always @(negedge clk) begin
        if (recT && nT < 4096) begin
            clkHist[nT]  = cmdClkT;
            dataHist[nT] = cmdDataT;
            nT = nT + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        wrStb  = v.wrStb;
        wrData = v.wrData;
        blank  = v.blank;
        ovfClr = v.ovfClr;
    endtask

    task automatic doReset();
        rst = 1'b1; wrStb = 1'b0; ovfClr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic waitRises(input int n, input int maxCyc, input string name);
        int k = 0;
        while (riseData.size() < n && k < maxCyc) begin
            tick();
            k++;
        end
        checkOutput(name, 64'(riseData.size()), 64'(n));
    endtask

    function automatic vec_t mkVec(input logic ws, input logic [CW-1:0] wd, input logic bl,
                                   input logic oc, input int lv, input logic fu, input logic em,
                                   input logic ov, input logic bu, input logic ck,
                                   input logic [CW-1:0] dt);
        vec_t v;
        v.wrStb = ws; v.wrData = wd; v.blank = bl; v.ovfClr = oc;
        v.expLevel = 5'(lv); v.expFull = fu; v.expEmpty = em; v.expOvf = ov;
        v.expBusy = bu; v.expClk = ck; v.expData = dt;
        return v;
    endfunction

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [8:0]    clkBits;
        logic [8:0]    busyBits;
        int            badData;
        int            badSpace;
        int            k;
        logic [CW-1:0] expQ[$];
        logic [CW-1:0] expDrain[$];
        int            strobes;
        int            pushed;

        // Fill the overflow / simultaneous push-pop vector table
        for (int i = 0; i < 16; i++) begin
            vecs[i] = mkVec(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, i + 1, (i == 15), 1'b0,
                            1'b0, 1'b0, 1'b0, 32'h0);
        end
        vecs[16] = mkVec(1, 32'hBAD0BAD0, 0, 0, 16, 1, 0, 1, 0, 0, 32'h0);
        vecs[17] = mkVec(0, 32'h0,        0, 1, 16, 1, 0, 0, 0, 0, 32'h0);
        vecs[18] = mkVec(1, 32'hBAD1BAD1, 0, 1, 16, 1, 0, 1, 0, 0, 32'h0);
        vecs[19] = mkVec(0, 32'h0,        0, 1, 16, 1, 0, 0, 0, 0, 32'h0);
        vecs[20] = mkVec(1, 32'hBAD2BAD2, 1, 0, 15, 0, 0, 1, 1, 0, 32'h100);
        vecs[21] = mkVec(1, 32'h200,      0, 0, 16, 1, 0, 1, 1, 1, 32'h100);
        vecs[22] = mkVec(0, 32'h0,        0, 1, 16, 1, 0, 0, 1, 1, 32'h100);

        rst = 1'b1; wrStb = 1'b0; wrData = '0; blank = 1'b0; ovfClr = 1'b0;
        rstT = 1'b1; wrStbT = 1'b0; wrDataT = '0; blankT = 1'b0; ovfClrT = 1'b0;

        // Reset for two cycles, then idle
        tick(); tick();
        checkOutput("reset_flags", 64'({full, empty, overflow, busy, cmdClk}), 64'(5'b01000));
        checkOutput("reset_level", 64'(level), 64'd0);
        checkOutput("reset_data", 64'(cmdData), 64'd0);
        checkOutput("reset_sent", 64'(sentCount), 64'd0);
        rst = 1'b0; rstT = 1'b0;
        blank = 1'b1;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cmdClk) k++;
        end
        checkOutput("idle_no_strobe", 64'(k), 64'd0);

        // Single command: push at cycle t, sample after each following edge
        wrStb = 1'b1; wrData = 32'hDEADBEEF;
        tick();
        wrStb = 1'b0;
        clkBits = '0; busyBits = '0; badData = 0;
        for (int s = 1; s <= 8; s++) begin
            clkBits[s]  = cmdClk;
            busyBits[s] = busy;
            if (s == 1 && cmdData !== 32'h0) badData++;
            if (s >= 2 && cmdData !== 32'hDEADBEEF) badData++;
            if (s < 8) tick();
        end
        checkOutput("single_data_timing", 64'(badData), 64'd0);
        checkOutput("single_strobe_cycles", 64'(clkBits), 64'(9'b0_0001_1000));
        checkOutput("single_busy_cycles", 64'(busyBits), 64'(9'b0_0011_1100));
        checkOutput("single_sent", 64'(sentCount), 64'd1);

        // Blank gating: queue three words while active video
        doReset();
        blank = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wrStb = 1'b1; wrData = 32'(i);
            tick();
        end
        wrStb = 1'b0;
        riseData.delete(); riseCyc.delete();
        for (int i = 0; i < 10; i++) tick();
        checkOutput("gate_no_strobe", 64'(riseData.size()), 64'd0);
        checkOutput("gate_level", 64'(level), 64'd3);
        blank = 1'b1;
        waitRises(2, 40, "gate_two_rises");
        blank = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("gate_stopped_at_two", 64'(riseData.size()), 64'd2);
        if (riseData.size() >= 2) begin
            checkOutput("gate_word0", 64'(riseData[0]), 64'd1);
            checkOutput("gate_word1", 64'(riseData[1]), 64'd2);
            checkOutput("gate_spacing", 64'(riseCyc[1] - riseCyc[0]), 64'd5);
        end
        checkOutput("gate_held_level", 64'(level), 64'd1);
        checkOutput("gate_idle_busy", 64'(busy), 64'd0);
        checkOutput("gate_sent2", 64'(sentCount), 64'd2);
        blank = 1'b1;
        waitRises(3, 20, "gate_third_rise");
        if (riseData.size() >= 3) checkOutput("gate_word2", 64'(riseData[2]), 64'd3);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("gate_sent3", 64'(sentCount), 64'd3);

        // Overflow and simultaneous push/pop table
        doReset();
        riseData.delete(); riseCyc.delete();
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i),
                        64'({level, full, empty, overflow, busy, cmdClk, cmdData}),
                        64'({vecs[i].expLevel, vecs[i].expFull, vecs[i].expEmpty, vecs[i].expOvf,
                             vecs[i].expBusy, vecs[i].expClk, vecs[i].expData}));
        end
        wrStb = 1'b0; ovfClr = 1'b0;

        // Drain: every accepted word in order, dropped words never appear
        blank = 1'b1;
        for (int i = 0; i < 16; i++) expDrain.push_back(32'(32'h100 + i));
        expDrain.push_back(32'h200);
        waitRises(17, 300, "drain_rises");
        for (int i = 0; i < 6; i++) tick();
        badData = 0; badSpace = 0;
        for (int i = 0; i < 17 && i < riseData.size(); i++) begin
            if (riseData[i] !== expDrain[i]) badData++;
            if (i > 0 && (riseCyc[i] - riseCyc[i-1]) != 5) badSpace++;
        end
        checkOutput("drain_order", 64'(badData), 64'd0);
        checkOutput("drain_spacing", 64'(badSpace), 64'd0);
        checkOutput("drain_sent", 64'(sentCount), 64'd17);
        checkOutput("drain_empty", 64'({empty, full, level}), 64'({1'b1, 1'b0, 5'd0}));

        // Reset while the strobe is high
        doReset();
        blank = 1'b1;
        wrStb = 1'b1; wrData = 32'hA5A5A5A5; tick();
        wrData = 32'h5A5A5A5A; tick();
        wrStb = 1'b0;
        k = 0;
        while (!cmdClk && k < 20) begin tick(); k++; end
        checkOutput("rstpulse_reached", 64'(cmdClk), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstpulse_outputs", 64'({cmdClk, busy, empty, level, sentCount, cmdData}),
                    64'({1'b0, 1'b0, 1'b1, 5'd0, 16'd0, 32'd0}));
        k = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (cmdClk) k++; end
        checkOutput("rstpulse_quiet", 64'(k), 64'd0);

        // Timing sweep with random traffic and random blanking
        rstT = 1'b1; tick(); rstT = 1'b0;
        recT = 1'b1;
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 20; c++) begin
            blankT = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 2) == 0 && !fullT) begin
                wrStbT  = 1'b1;
                wrDataT = $urandom;
                expQ.push_back(wrDataT);
                pushed++;
            end else begin
                wrStbT = 1'b0;
            end
            tick();
        end
        wrStbT = 1'b0; blankT = 1'b1;
        k = 0;
        while ((sentCountT != 16'd20 || busyT) && k < 600) begin tick(); k++; end
        for (int i = 0; i < 4; i++) tick();
        recT = 1'b0;
        tick();

        strobes = 0;
        for (int r = 1; r < nT; r++) begin
            if (clkHist[r] && !clkHist[r-1]) begin
                int bad = 0;
                if (r < TS || r + TP + TH > nT) begin
                    bad++;
                end else begin
                    for (int j = r - TS; j < r + TP + TH; j++) begin
                        if (dataHist[j] !== dataHist[r]) bad++;
                        if (clkHist[j] !== ((j >= r) && (j < r + TP))) bad++;
                    end
                end
                checkOutput($sformatf("sweep_window%0d", strobes), 64'(bad), 64'd0);
                if (strobes < expQ.size()) begin
                    checkOutput($sformatf("sweep_word%0d", strobes), 64'(dataHist[r]), 64'(expQ[strobes]));
                end
                strobes++;
            end
        end
        checkOutput("sweep_pushed", 64'(pushed), 64'd20);
        checkOutput("sweep_strobes", 64'(strobes), 64'd20);
        checkOutput("sweep_sent", 64'(sentCountT), 64'd20);
        checkOutput("sweep_no_overflow", 64'(overflowT), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
